// File: rtl/html_tokenizer.sv
// html_tokenizer
//   Splits the character stream from the HTML file reader into tokens:
//   single TEXT characters, OPEN_TAG / CLOSE_TAG tokens carrying the tag name,
//   and one final EOF token.
//
// Ports
//   clock         system clock, rising edge
//   state_enable  asynchronous active-low reset
//   in_char       character from the reader (0 = null, ignored)
//   in_finished   reader has finished
//   pause         backpressure to the reader (tok_valid | done)
//   tok_valid     token presented
//   tok_ready     downstream accepts the token
//   tok_type      0 TEXT, 1 OPEN_TAG, 2 CLOSE_TAG, 3 EOF
//   tok_name      token characters, character 0 in bits [CHAR_W-1:0]
//   tok_len       number of valid characters in tok_name
//   err           sticky malformed-markup flag
//   done          EOF token has been accepted
//   dbg_state     current FSM state, for observation only
//
// Token handshake: a token transfers on a rising edge where tok_valid and
// tok_ready are both 1. tok_* are held while tok_valid=1 and tok_ready=0;
// tok_ready is ignored while tok_valid=0.
//
// Optional feature: define HTML_TOKENIZER_CASEFOLD_EN to store tag-name
// letters A-Z lower-cased. TEXT characters are never folded.
module html_tokenizer #(
    parameter  int CHAR_W   = 8,
    parameter  int NAME_LEN = 8,
    localparam int LEN_W    = $clog2(NAME_LEN + 1)
) (
    input  logic                       clock,
    input  logic                       state_enable,
    input  logic [CHAR_W-1:0]          in_char,
    input  logic                       in_finished,
    output logic                       pause,
    output logic                       tok_valid,
    input  logic                       tok_ready,
    output logic [1:0]                 tok_type,
    output logic [NAME_LEN*CHAR_W-1:0] tok_name,
    output logic [LEN_W-1:0]           tok_len,
    output logic                       err,
    output logic                       done,
    output logic [2:0]                 dbg_state
);

    typedef enum logic [2:0] {
        S_TEXT, S_LT, S_NAME, S_ATTR, S_EOFW, S_DONE
    } state_t;

    localparam logic [1:0] T_TEXT  = 2'd0;
    localparam logic [1:0] T_OPEN  = 2'd1;
    localparam logic [1:0] T_CLOSE = 2'd2;
    localparam logic [1:0] T_EOF   = 2'd3;

    localparam logic [CHAR_W-1:0] C_LT   = CHAR_W'(8'h3C);
    localparam logic [CHAR_W-1:0] C_GT   = CHAR_W'(8'h3E);
    localparam logic [CHAR_W-1:0] C_SL   = CHAR_W'(8'h2F);
    localparam logic [CHAR_W-1:0] C_UA   = CHAR_W'(8'h41);
    localparam logic [CHAR_W-1:0] C_UZ   = CHAR_W'(8'h5A);
    localparam logic [CHAR_W-1:0] C_LA   = CHAR_W'(8'h61);
    localparam logic [CHAR_W-1:0] C_LZ   = CHAR_W'(8'h7A);
    localparam logic [CHAR_W-1:0] C_D0   = CHAR_W'(8'h30);
    localparam logic [CHAR_W-1:0] C_D9   = CHAR_W'(8'h39);
    localparam logic [CHAR_W-1:0] C_CASE = CHAR_W'(8'h20);

    state_t                      state, state_n;
    logic                        closing, closing_n;
    logic [NAME_LEN*CHAR_W-1:0]  name_buf, buf_n;
    logic [LEN_W-1:0]            name_cnt, cnt_n;
    logic                        valid_n, err_n, done_n;
    logic [1:0]                  type_n;
    logic [NAME_LEN*CHAR_W-1:0]  name_n;
    logic [LEN_W-1:0]            len_n;
    logic                        accept, emit_tag, is_letter, is_digit;

    function automatic logic [CHAR_W-1:0] fold(input logic [CHAR_W-1:0] ch);
        fold = ch;
`ifdef HTML_TOKENIZER_CASEFOLD_EN
        if (ch >= C_UA && ch <= C_UZ) fold = ch + C_CASE;
`endif
    endfunction

    // pause depends only on registered state, so it never glitches on inputs.
    assign pause     = tok_valid | done;
    assign accept    = !pause && !in_finished && (in_char != '0);
    assign is_letter = (in_char >= C_UA && in_char <= C_UZ) ||
                       (in_char >= C_LA && in_char <= C_LZ);
    assign is_digit  = (in_char >= C_D0 && in_char <= C_D9);
    assign dbg_state = state;

    always_comb begin
        state_n   = state;
        closing_n = closing;
        buf_n     = name_buf;
        cnt_n     = name_cnt;
        valid_n   = tok_valid;
        type_n    = tok_type;
        name_n    = tok_name;
        len_n     = tok_len;
        err_n     = err;
        done_n    = done;
        emit_tag  = 1'b0;

        if (tok_valid && tok_ready) begin
            valid_n = 1'b0;
            if (state == S_EOFW) begin
                state_n = S_DONE;
                done_n  = 1'b1;
            end
        end

        // EOF waits until no token is pending, so earlier tokens go first.
        if (in_finished && !tok_valid && state != S_EOFW && state != S_DONE) begin
            valid_n = 1'b1;
            type_n  = T_EOF;
            name_n  = '0;
            len_n   = '0;
            state_n = S_EOFW;
            if (state == S_LT || state == S_NAME || state == S_ATTR) err_n = 1'b1;
        end else if (accept) begin
            case (state)
                S_TEXT: begin
                    if (in_char == C_LT) begin
                        state_n   = S_LT;
                        buf_n     = '0;
                        cnt_n     = '0;
                        closing_n = 1'b0;
                    end else begin
                        valid_n              = 1'b1;
                        type_n               = T_TEXT;
                        name_n               = '0;
                        name_n[CHAR_W-1:0]   = in_char;
                        len_n                = LEN_W'(1);
                    end
                end
                S_LT: begin
                    if (in_char == C_SL) begin
                        closing_n = 1'b1;
                        state_n   = S_NAME;
                    end else if (is_letter) begin
                        buf_n[CHAR_W-1:0] = fold(in_char);
                        cnt_n             = LEN_W'(1);
                        state_n           = S_NAME;
                    end else begin
                        err_n   = 1'b1;
                        state_n = S_TEXT;
                    end
                end
                S_NAME: begin
                    if (is_letter || is_digit) begin
                        // Names longer than NAME_LEN are truncated silently.
                        if (int'(name_cnt) < NAME_LEN) begin
                            for (int i = 0; i < NAME_LEN; i++) begin
                                if (int'(name_cnt) == i) buf_n[i*CHAR_W +: CHAR_W] = fold(in_char);
                            end
                            cnt_n = name_cnt + LEN_W'(1);
                        end
                    end else if (in_char == C_GT) begin
                        emit_tag = 1'b1;
                    end else begin
                        state_n = S_ATTR;
                    end
                end
                S_ATTR: begin
                    if (in_char == C_GT) emit_tag = 1'b1;
                end
                default: ;
            endcase

            if (emit_tag) begin
                valid_n = 1'b1;
                type_n  = closing ? T_CLOSE : T_OPEN;
                name_n  = name_buf;
                len_n   = name_cnt;
                state_n = S_TEXT;
                if (name_cnt == '0) err_n = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge state_enable) begin
        if (!state_enable) begin
            state     <= S_TEXT;
            closing   <= 1'b0;
            name_buf  <= '0;
            name_cnt  <= '0;
            tok_valid <= 1'b0;
            tok_type  <= T_TEXT;
            tok_name  <= '0;
            tok_len   <= '0;
            err       <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            closing   <= closing_n;
            name_buf  <= buf_n;
            name_cnt  <= cnt_n;
            tok_valid <= valid_n;
            tok_type  <= type_n;
            tok_name  <= name_n;
            tok_len   <= len_n;
            err       <= err_n;
            done      <= done_n;
        end
    end

endmodule

// File: tb/tb_html_tokenizer.sv
// tb_html_tokenizer
//   Table of single-token input strings with expected tokens, plus
//   hand-written sequences for backpressure, errors, EOF and async reset.
//   Expected tokens are pushed to exp_q as stimulus is driven and popped when
//   the tokenizer presents a new token.
module tb_html_tokenizer;

    localparam int EW = 2 + 4 + 64;

    logic        clock = 1'b0;
    logic        state_enable;
    logic [7:0]  in_char;
    logic        in_finished;
    logic        pause;
    logic        tok_valid;
    logic        tok_ready;
    logic [1:0]  tok_type;
    logic [63:0] tok_name;
    logic [3:0]  tok_len;
    logic        err;
    logic        done;
    logic [2:0]  dbg_state;

    html_tokenizer #(.CHAR_W(8), .NAME_LEN(8)) dut (
        .clock(clock), .state_enable(state_enable), .in_char(in_char),
        .in_finished(in_finished), .pause(pause), .tok_valid(tok_valid),
        .tok_ready(tok_ready), .tok_type(tok_type), .tok_name(tok_name),
        .tok_len(tok_len), .err(err), .done(done), .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clock = ~clock;

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q[$];
    int            n_vec  = 0;
    int            n_fail = 0;
    logic          presented = 1'b0;

    typedef struct {
        logic [127:0] stim;
        logic [1:0]   typ;
        logic [63:0]  nm;
        logic [3:0]   len;
    } vec_t;
    vec_t vt[10];

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Right-justified string literal -> tok_name layout (char 0 in low byte).
    function automatic logic [63:0] to_name(input logic [63:0] s, input logic [1:0] typ);
        logic [63:0] r = '0;
        logic [7:0]  ch;
        int          k = 0;
        for (int i = 7; i >= 0; i--) begin
            ch = s[i*8 +: 8];
            if (ch != 8'h00) begin
`ifdef HTML_TOKENIZER_CASEFOLD_EN
                if (typ != 2'd0 && ch >= 8'h41 && ch <= 8'h5A) ch = ch + 8'h20;
`endif
                r[k*8 +: 8] = ch;
                k++;
            end
        end
        return r;
    endfunction

    task automatic push_exp(input logic [1:0] typ, input logic [63:0] s, input logic [3:0] len);
        exp_q.push_back({typ, len, to_name(s, typ)});
    endtask

    // Compare a newly presented token with the head of the queue; only the
    // first tok_len characters of the name are significant.
    task automatic monitor();
        logic [EW-1:0] e;
        logic [63:0]   gm, em;
        if (tok_valid && !presented) begin
            presented = 1'b1;
            if (exp_q.size() == 0) begin
                chk("unexpected_token", {tok_type, tok_len, tok_name}, '0);
            end else begin
                e  = exp_q.pop_front();
                gm = '0;
                em = '0;
                for (int i = 0; i < 8; i++) begin
                    if (i < int'(e[67:64])) begin
                        gm[i*8 +: 8] = tok_name[i*8 +: 8];
                        em[i*8 +: 8] = e[i*8 +: 8];
                    end
                end
                chk("token", {tok_type, tok_len, gm}, {e[69:68], e[67:64], em});
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic cycle();
        logic hs;
        hs = tok_valid && tok_ready;
        @(posedge clock);
        #1;
        if (hs) presented = 1'b0;
        monitor();
    endtask

    task automatic feed_char(input logic [7:0] c);
        logic acc;
        int   b = 0;
        in_char     = c;
        in_finished = 1'b0;
        do begin
            acc = !pause;
            cycle();
            b++;
        end while (!acc && b < 50);
        if (!acc) chk("feed_timeout", 1, 0);
        in_char = 8'h00;
    endtask

    task automatic feed_str(input logic [127:0] s);
        for (int i = 15; i >= 0; i--) begin
            if (s[i*8 +: 8] != 8'h00) feed_char(s[i*8 +: 8]);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_pause"}, pause, 0);
        chk({tag, "_valid"}, tok_valid, 0);
        chk({tag, "_type"}, tok_type, 0);
        chk({tag, "_name"}, tok_name, 0);
        chk({tag, "_len"}, tok_len, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    task automatic do_reset();
        state_enable = 1'b0;
        in_char      = 8'h00;
        in_finished  = 1'b0;
        tok_ready    = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        exp_q.delete();
        presented = 1'b0;
        @(negedge clock);
        state_enable = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic finish_run(input logic exp_err, input string tag);
        int b = 0;
        push_exp(2'd3, 64'h0, 4'd0);
        in_char     = 8'h00;
        in_finished = 1'b1;
        while (!done && b < 20) begin
            cycle();
            b++;
        end
        chk({tag, "_done"}, done, 1);
        chk({tag, "_err"}, err, exp_err);
        chk({tag, "_pause"}, pause, 1);
        chk({tag, "_queue_empty"}, exp_q.size(), 0);
        in_finished = 1'b0;
    endtask

    // ---------------- test ----------------
    initial begin
        vt[0] = '{"<p>",            2'd1, "p",        4'd1};
        vt[1] = '{"</DIV>",         2'd2, "DIV",      4'd3};
        vt[2] = '{"<abcdefghij>",   2'd1, "abcdefgh", 4'd8};
        vt[3] = '{"<a href=\"x\">", 2'd1, "a",        4'd1};
        vt[4] = '{"x",              2'd0, "x",        4'd1};
        vt[5] = '{"<h1>",           2'd1, "h1",       4'd2};
        vt[6] = '{"</b c>",         2'd2, "b",        4'd1};
        vt[7] = '{"<br/>",          2'd1, "br",       4'd2};
        vt[8] = '{"Z",              2'd0, "Z",        4'd1};
        vt[9] = '{"<Ab9 >",         2'd1, "Ab9",      4'd3};

        // Table vectors, then EOF with no error.
        do_reset();
        check_reset_outputs("reset");
        for (int i = 0; i < 10; i++) begin
            push_exp(vt[i].typ, vt[i].nm, vt[i].len);
            feed_str(vt[i].stim);
        end
        cycle();
        chk("table_queue_empty", exp_q.size(), 0);
        chk("table_err", err, 0);
        finish_run(1'b0, "eof_clean");

        // Backpressure: a<b with tok_ready low for 5 cycles after the TEXT token.
        do_reset();
        push_exp(2'd0, "a", 4'd1);
        feed_char(8'h61);
        tok_ready = 1'b0;
        in_char   = 8'h3C;
        for (int i = 0; i < 5; i++) begin
            chk("bp_pause_high", pause, 1);
            cycle();
        end
        chk("bp_held_name", tok_name[7:0], 8'h61);
        chk("bp_held_valid", tok_valid, 1);
        tok_ready = 1'b1;
        cycle();
        chk("bp_pause_low", pause, 0);
        chk("bp_valid_low", tok_valid, 0);
        push_exp(2'd1, "b", 4'd1);
        feed_str("<b>");
        cycle();
        chk("bp_queue_empty", exp_q.size(), 0);
        chk("bp_err", err, 0);

        // Empty closing tag sets err.
        do_reset();
        push_exp(2'd2, 64'h0, 4'd0);
        feed_str("</>");
        cycle();
        chk("empty_err", err, 1);
        chk("empty_queue_empty", exp_q.size(), 0);

        // Unterminated tag at end of input.
        do_reset();
        feed_str("<p");
        finish_run(1'b1, "eof_partial");

        // Bad character after '<', then async reset while in NAME.
        do_reset();
        feed_str("<1");
        chk("lt_bad_err", err, 1);
        chk("lt_bad_no_token", tok_valid, 0);
        feed_str("<p");
        chk("name_state", dbg_state, 3'd2);
        state_enable = 1'b0;
        #2;
        check_reset_outputs("async");
        chk("async_state", dbg_state, 3'd0);
        state_enable = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/html_tokenizer.md
# html_tokenizer

Consumes the character stream produced by the HTML file reader and drives that reader's `pause` input, so it is the receiving end of the reader's char/pause/finished interface. It splits the stream into tokens: single text characters, opening tags and closing tags, followed by one final end-of-file token. Tokens are presented on a valid/ready interface to the downstream layout/render stage.

## Interface
Parameters:
- `CHAR_W`, 8: width of one character; matches `` `CHAR_BITES ``.
- `NAME_LEN`, 8: maximum number of tag-name characters stored.

Ports:
- `clock`  in  1  system clock; all state changes on the rising edge.
- `state_enable`  in  1  reset; asynchronous, active-low (0 = reset).
- `in_char`  in  CHAR_W  character from the reader.
- `in_finished`  in  1  reader `has_finished`.
- `pause`  out  1  backpressure to the reader.
- `tok_valid`  out  1  a token is presented.
- `tok_ready`  in  1  downstream accepts the token.
- `tok_type`  out  2  token type: 0 TEXT, 1 OPEN_TAG, 2 CLOSE_TAG, 3 EOF.
- `tok_name`  out  NAME_LEN*CHAR_W  token characters; character 0 occupies bits [CHAR_W-1:0].
- `tok_len`  out  $clog2(NAME_LEN+1)  number of valid characters in `tok_name`.
- `err`  out  1  sticky flag for malformed markup.
- `done`  out  1  the EOF token has been accepted.

## Operation
- **Character acceptance:** a character is accepted on a rising edge when all of the following hold:
  - `state_enable`=1
  - `pause`=0
  - `in_finished`=0
  - `in_char`≠0 (0 is null and is ignored)
- **pause:** `pause` = `tok_valid` | `done`. It is purely combinational from registered state, so no character is lost while a token is pending.
- **Output register:** a single entry. `tok_*` are held stable while `tok_valid`=1 and `tok_ready`=0.
- **State machine:** TEXT, LT, NAME, ATTR, EOFW, DONE. TEXT is the reset state.
  - **TEXT:**
    - `<` → LT; the name buffer is cleared and `closing`=0.
    - Any other character → TEXT token with `tok_name[CHAR_W-1:0]`=char and `tok_len`=1.
  - **LT:**
    - `/` → NAME with `closing`=1.
    - Letter → store it; go to NAME.
    - Any other character → `err`=1, both characters are dropped, go to TEXT.
  - **NAME:**
    - Letter or digit → appended if fewer than NAME_LEN characters are stored; otherwise silently dropped (truncation does not set `err`).
    - Space, tab, CR, LF or `/` → ATTR.
    - `>` → emit OPEN_TAG, or CLOSE_TAG if `closing`=1, then go to TEXT.
    - Any other character → ATTR.
  - **ATTR:** all characters are discarded until `>`, which emits the tag as in NAME and goes to TEXT.
  - **Empty name:** a tag emitted with 0 stored characters (for example `</>`) is emitted with `tok_len`=0 and sets `err`.
  - **End of input:** `in_finished`=1 seen in any state other than DONE/EOFW, with `tok_valid`=0 → emit EOF (`tok_len`=0), go to EOFW. If the current state was LT, NAME or ATTR, `err` is also set. A pending token is always delivered before EOF.
  - **EOFW:** on EOF acceptance → DONE and `done`=1. DONE is held until reset.
- **Reset mid-operation:** clears all state immediately, including a pending token. The partial tag is lost.

## Timing
- **Reset values:**
  - `pause`=0, `tok_valid`=0, `tok_type`=0, `tok_name`=0, `tok_len`=0, `err`=0, `done`=0
  - Internal: state TEXT, `closing`=0, name count 0.
- **Latency:** `tok_valid` rises on the edge that accepts the completing character (`>` or a text character).
- **Handshake:** the token is transferred on an edge with `tok_valid`&`tok_ready`. `tok_valid` falls on that same edge, so `pause` falls in the following cycle.
- **Throughput:** at most one accepted character per cycle. A token costs at least 2 cycles: emit, then accept.
- **Simultaneous events:**
  - `in_finished` and a pending token: the token goes first, then EOF.
  - `tok_ready` is ignored when `tok_valid`=0.
- **Arithmetic:** the name count saturates at NAME_LEN. Case folding is `char`+8'h20 for `A`–`Z` only.

## Configuration
- `HTML_TOKENIZER_CASEFOLD_EN` defined: tag-name letters `A`–`Z` are stored lower-cased. TEXT characters are never folded.
- Undefined: tag-name characters are stored exactly as received.

## Test plan
- `<p>`, `tok_ready`=1 → one OPEN_TAG with `tok_name[7:0]`=8'h70, `tok_len`=1; then `in_finished` → EOF, then `done`=1 and `err`=0.
- `</DIV>` → CLOSE_TAG, `tok_len`=3. With the macro the characters are 8'h64,8'h69,8'h76; without it they are 8'h44,8'h49,8'h56.
- `a<b>` with `tok_ready` held 0 for 5 cycles after the first token → `pause`=1 for exactly those cycles. Result: TEXT 8'h61, then OPEN_TAG 8'h62; no character dropped or duplicated.
- `<abcdefghij>` with NAME_LEN=8 → OPEN_TAG with `tok_len`=8 and characters `abcdefgh`; `err`=0.
- `<a href="x">` → OPEN_TAG `a`, `tok_len`=1; the next text character is emitted as TEXT.
- `<p` then `in_finished` → EOF with `err`=1. A separate run deasserts `state_enable` while in NAME → all outputs return to their reset values asynchronously and `pause`=0.
